// File: rtl/pool2_fc_feeder.sv
// rtl/pool2_fc_feeder.sv - 2x2 stride-2 signed max-pool feeding the FC layer, CI channels per beat.
// Optional POOL_RELU_EN clamps negative pooled results to zero inside the output register.
module pool2_fc_feeder #(
  parameter int I_BW    = 32,
  parameter int CI      = 3,
  parameter int IN_SIZE = 8
) (
  input  logic               clk,
  input  logic               global_rst_n,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [CI*I_BW-1:0] i_data,
  output logic               o_valid,
  output logic [CI*I_BW-1:0] o_data,
  output logic               o_frame_done
);

  localparam int HALF = IN_SIZE / 2;
  localparam int CW   = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

  logic [CW-1:0]      col_q, col_d, row_q, row_d;
  logic [CW-1:0]      beat_col, beat_row;
  logic [HW-1:0]      lb_idx;
  logic [CI*I_BW-1:0] h_q, h_d;
  logic [CI*I_BW-1:0] linebuf_q [HALF];
  logic [CI*I_BW-1:0] linebuf_d [HALF];
  logic [CI*I_BW-1:0] pm, res;
  logic [CI*I_BW-1:0] o_data_q, o_data_d;
  logic               o_valid_q, o_valid_d;
  logic               o_frame_done_q, o_frame_done_d;

  function automatic logic [I_BW-1:0] smax(input logic [I_BW-1:0] a, input logic [I_BW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  always_comb begin
    // A start-of-frame beat is always treated as position (0,0).
    beat_col       = i_sof ? '0 : col_q;
    beat_row       = i_sof ? '0 : row_q;
    lb_idx         = HW'(beat_col >> 1);
    col_d          = col_q;
    row_d          = row_q;
    h_d            = h_q;
    linebuf_d      = linebuf_q;
    o_valid_d      = 1'b0;
    o_frame_done_d = 1'b0;
    o_data_d       = o_data_q;
    pm             = '0;
    res            = '0;

    for (int c = 0; c < CI; c++) begin
      pm[c*I_BW +: I_BW]  = smax(h_q[c*I_BW +: I_BW], i_data[c*I_BW +: I_BW]);
      res[c*I_BW +: I_BW] = smax(linebuf_q[lb_idx][c*I_BW +: I_BW], pm[c*I_BW +: I_BW]);
`ifdef POOL_RELU_EN
      if (res[c*I_BW + I_BW - 1]) res[c*I_BW +: I_BW] = '0;
`endif
    end

    if (rst) begin
      col_d    = '0;
      row_d    = '0;
      o_data_d = '0;
    end else if (i_valid) begin
      if (!beat_col[0]) begin
        h_d = i_data;
      end else if (!beat_row[0]) begin
        linebuf_d[lb_idx] = pm;
      end else begin
        o_valid_d      = 1'b1;
        o_data_d       = res;
        o_frame_done_d = (beat_col == LAST) && (beat_row == LAST);
      end
      if (beat_col == LAST) begin
        col_d = '0;
        row_d = (beat_row == LAST) ? '0 : beat_row + CW'(1);
      end else begin
        col_d = beat_col + CW'(1);
        row_d = beat_row;
      end
    end else if (i_sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col_q          <= '0;
      row_q          <= '0;
      o_valid_q      <= 1'b0;
      o_frame_done_q <= 1'b0;
      o_data_q       <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      o_valid_q      <= o_valid_d;
      o_frame_done_q <= o_frame_done_d;
      o_data_q       <= o_data_d;
    end
  end

  // Pooling scratch is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    h_q       <= h_d;
    linebuf_q <= linebuf_d;
  end

  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_frame_done = o_frame_done_q;

endmodule
